// File: rtl/rx_pkt_arb.sv
// Two-channel packet arbiter: merges show-ahead FIFO streams into one, whole packets at a time,
// round robin, with truncation at MAX_LEN words and silent dropping of headless fragments.
module rx_pkt_arb #(
  parameter int unsigned MAX_LEN = 760
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ch0_data,
  input  logic        ch0_sop,
  input  logic        ch0_eop,
  input  logic        ch0_mod,
  input  logic        ch0_empty,
  input  logic        ch0_pkt_rdy,
  output logic        ch0_rdreq,
  input  logic [15:0] ch1_data,
  input  logic        ch1_sop,
  input  logic        ch1_eop,
  input  logic        ch1_mod,
  input  logic        ch1_empty,
  input  logic        ch1_pkt_rdy,
  output logic        ch1_rdreq,
  input  logic        dout_rdy,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_mod,
  output logic        gnt_id,
  output logic        len_err
);

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StSend, StDrop} state_e;

  state_e      state_q;
  logic        last_q;
  logic [10:0] cnt_q;
  logic [10:0] cnt_nxt;

  logic [15:0] h_data;
  logic        h_sop, h_eop, h_mod, h_empty;
  logic        pop;
  logic        pick;

  always_comb begin
    h_data  = gnt_id ? ch1_data  : ch0_data;
    h_sop   = gnt_id ? ch1_sop   : ch0_sop;
    h_eop   = gnt_id ? ch1_eop   : ch0_eop;
    h_mod   = gnt_id ? ch1_mod   : ch0_mod;
    h_empty = gnt_id ? ch1_empty : ch0_empty;
  end

  // Gated by rst_n so no word is lost while reset holds the FSM.
  always_comb begin
    pop = 1'b0;
    if (rst_n) begin
      case (state_q)
        StSend:  pop = !h_empty && dout_rdy;
        StDrop:  pop = !h_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  assign ch0_rdreq = pop && !gnt_id;
  assign ch1_rdreq = pop && gnt_id;

  // Contention goes to the channel not served last; a lone requester always wins.
  assign pick    = (ch0_pkt_rdy && ch1_pkt_rdy) ? !last_q : ch1_pkt_rdy;
  assign cnt_nxt = cnt_q + 11'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      gnt_id   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_mod <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_mod <= 1'b0;
      len_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ch0_pkt_rdy || ch1_pkt_rdy) begin
            gnt_id  <= pick;
            cnt_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (pop) begin
            cnt_q <= cnt_nxt;
            if (cnt_q == '0 && !h_sop) begin
              // Headless fragment: discard up to and including its eop.
              if (h_eop) begin
                state_q <= StIdle;
                last_q  <= gnt_id;
              end else begin
                state_q <= StDrop;
              end
            end else begin
              dout     <= h_data;
              dout_vld <= 1'b1;
              dout_sop <= h_sop;
              dout_mod <= h_mod;
              if (h_eop) begin
                dout_eop <= 1'b1;
                state_q  <= StIdle;
                last_q   <= gnt_id;
              end else if (cnt_nxt == MaxLen) begin
                dout_eop <= 1'b1;
                dout_mod <= 1'b0;
                len_err  <= 1'b1;
                state_q  <= StDrop;
              end
            end
          end
        end
        StDrop: begin
          if (pop && h_eop) begin
            state_q <= StIdle;
            last_q  <= gnt_id;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pkt_arb.sv
// Scoreboard bench for rx_pkt_arb: queue-modelled channel FIFOs, expected words queued up front
// and matched as dout_vld appears; a second instance with MAX_LEN=4 covers truncation.
module tb_rx_pkt_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        dout_rdy = 1'b1;
  logic [15:0] ch0_data = '0, ch1_data = '0;
  logic        ch0_sop = 0, ch0_eop = 0, ch0_mod = 0, ch0_empty = 1, ch0_pkt_rdy = 0;
  logic        ch1_sop = 0, ch1_eop = 0, ch1_mod = 0, ch1_empty = 1, ch1_pkt_rdy = 0;

  logic        rd0_a, rd1_a, vld_a, sop_a, eop_a, mod_a, gnt_a, len_a;
  logic        rd0_b, rd1_b, vld_b, sop_b, eop_b, mod_b, gnt_b, len_b;
  logic [15:0] dout_a, dout_b;

  rx_pkt_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_data(ch0_data), .ch0_sop(ch0_sop), .ch0_eop(ch0_eop), .ch0_mod(ch0_mod),
    .ch0_empty(ch0_empty), .ch0_pkt_rdy(ch0_pkt_rdy), .ch0_rdreq(rd0_a),
    .ch1_data(ch1_data), .ch1_sop(ch1_sop), .ch1_eop(ch1_eop), .ch1_mod(ch1_mod),
    .ch1_empty(ch1_empty), .ch1_pkt_rdy(ch1_pkt_rdy), .ch1_rdreq(rd1_a),
    .dout_rdy(dout_rdy), .dout(dout_a), .dout_vld(vld_a), .dout_sop(sop_a),
    .dout_eop(eop_a), .dout_mod(mod_a), .gnt_id(gnt_a), .len_err(len_a)
  );

  rx_pkt_arb #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ch0_data(ch0_data), .ch0_sop(ch0_sop), .ch0_eop(ch0_eop), .ch0_mod(ch0_mod),
    .ch0_empty(ch0_empty), .ch0_pkt_rdy(ch0_pkt_rdy), .ch0_rdreq(rd0_b),
    .ch1_data(ch1_data), .ch1_sop(ch1_sop), .ch1_eop(ch1_eop), .ch1_mod(ch1_mod),
    .ch1_empty(ch1_empty), .ch1_pkt_rdy(ch1_pkt_rdy), .ch1_rdreq(rd1_b),
    .dout_rdy(dout_rdy), .dout(dout_b), .dout_vld(vld_b), .dout_sop(sop_b),
    .dout_eop(eop_b), .dout_mod(mod_b), .gnt_id(gnt_b), .len_err(len_b)
  );

  logic        rd0_s, rd1_s, vld_s, sop_s, eop_s, mod_s, gnt_s, len_s;
  logic [15:0] dout_s;
  assign rd0_s  = sel ? rd0_b  : rd0_a;
  assign rd1_s  = sel ? rd1_b  : rd1_a;
  assign vld_s  = sel ? vld_b  : vld_a;
  assign sop_s  = sel ? sop_b  : sop_a;
  assign eop_s  = sel ? eop_b  : eop_a;
  assign mod_s  = sel ? mod_b  : mod_a;
  assign gnt_s  = sel ? gnt_b  : gnt_a;
  assign len_s  = sel ? len_b  : len_a;
  assign dout_s = sel ? dout_b : dout_a;

  // FIFO word: {sop, eop, mod, data}; expected entry: {gnt, len_err, sop, eop, mod, data}
  logic [18:0] q0[$], q1[$];
  logic [20:0] exp_q[$];
  int          checks = 0, errors = 0;
  int          len_err_cnt = 0;
  logic        prev_vld = 1'b0, seen_sop = 1'b0;
  logic        pop0_q = 1'b0, pop1_q = 1'b0;

  always @(posedge clk) begin
    pop0_q <= rd0_s;
    pop1_q <= rd1_s;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic refresh();
    ch0_empty = (q0.size() == 0);
    ch1_empty = (q1.size() == 0);
    if (q0.size() > 0) {ch0_sop, ch0_eop, ch0_mod, ch0_data} = q0[0];
    else {ch0_sop, ch0_eop, ch0_mod} = 3'b000;
    if (q1.size() > 0) {ch1_sop, ch1_eop, ch1_mod, ch1_data} = q1[0];
    else {ch1_sop, ch1_eop, ch1_mod} = 3'b000;
    ch0_pkt_rdy = 1'b0;
    ch1_pkt_rdy = 1'b0;
    foreach (q0[i]) if (q0[i][17]) ch0_pkt_rdy = 1'b1;
    foreach (q1[i]) if (q1[i][17]) ch1_pkt_rdy = 1'b1;
  endtask

  task automatic tick();
    logic [20:0] e;
    @(negedge clk);
    seen_sop = 1'b0;
    if (vld_s) begin
      check_eq("exp_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("word", 32'({gnt_s, len_s, sop_s, eop_s, mod_s, dout_s}), 32'(e));
      end
      if (sop_s) begin
        check_eq("idle_gap", 32'(prev_vld), 32'd0);
        seen_sop = 1'b1;
      end
    end else begin
      check_eq("quals_idle", 32'({sop_s, eop_s, mod_s}), 32'd0);
    end
    if (len_s) len_err_cnt++;
    prev_vld = vld_s;
    if (pop0_q && q0.size() > 0) void'(q0.pop_front());
    if (pop1_q && q1.size() > 0) void'(q1.pop_front());
    refresh();
  endtask

  task automatic pushw(input int ch, input logic s, input logic e, input logic m,
                       input logic [15:0] d);
    if (ch == 0) q0.push_back({s, e, m, d});
    else q1.push_back({s, e, m, d});
  endtask

  task automatic expw(input logic g, input logic l, input logic s, input logic e,
                      input logic m, input logic [15:0] d);
    exp_q.push_back({g, l, s, e, m, d});
  endtask

  task automatic do_reset(input logic which);
    sel = which;
    rst_n = 1'b0;
    dout_rdy = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    len_err_cnt = 0;
    check_eq("rst_outs", 32'({dout_s, vld_s, sop_s, eop_s, mod_s, len_s, gnt_s}), 32'd0);
    check_eq("rst_rdreq", 32'({rd0_s, rd1_s}), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_eq({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_fifo_left"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    // Both channels, 3-word packets; ch0 wins first contention after reset.
    do_reset(1'b0);
    for (int i = 1; i <= 3; i++) begin
      pushw(0, i == 1, i == 3, 1'b0, 16'hA000 + 16'(i));
      pushw(1, i == 1, i == 3, 1'b0, 16'hB000 + 16'(i));
    end
    for (int i = 1; i <= 3; i++) expw(1'b0, 1'b0, i == 1, i == 3, 1'b0, 16'hA000 + 16'(i));
    for (int i = 1; i <= 3; i++) expw(1'b1, 1'b0, i == 1, i == 3, 1'b0, 16'hB000 + 16'(i));
    refresh();
    for (int i = 0; i < 20 && !seen_sop; i++) tick();
    #1;
    check_eq("t1_rdreq", 32'({rd0_s, rd1_s}), 32'b10);
    drain("t1");
    check_eq("t1_len_err", 32'(len_err_cnt), 32'd0);

    // Only ch1, four back-to-back one-word packets.
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) begin
      pushw(1, 1'b1, 1'b1, i[0], 16'hC000 + 16'(i));
      expw(1'b1, 1'b0, 1'b1, 1'b1, i[0], 16'hC000 + 16'(i));
    end
    refresh();
    drain("t2");

    // Five-word packet with dout_rdy low on SEND cycles 2 and 3.
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) begin
      pushw(0, i == 1, i == 5, i == 5, 16'hD000 + 16'(i));
      expw(1'b0, 1'b0, i == 1, i == 5, i == 5, 16'hD000 + 16'(i));
    end
    refresh();
    for (int i = 0; i < 20 && !seen_sop; i++) tick();
    check_eq("t3_sop_seen", 32'(seen_sop), 32'd1);
    dout_rdy = 1'b0;
    #1;
    check_eq("t3_stall_rd_a", 32'({rd0_s, rd1_s}), 32'd0);
    tick();
    #1;
    check_eq("t3_stall_vld_a", 32'(vld_s), 32'd0);
    check_eq("t3_stall_rd_b", 32'({rd0_s, rd1_s}), 32'd0);
    tick();
    check_eq("t3_stall_vld_b", 32'(vld_s), 32'd0);
    dout_rdy = 1'b1;
    drain("t3");

    // MAX_LEN=4 instance: 6-word ch0 packet truncated, then ch1 wins over ch0's next packet.
    do_reset(1'b1);
    for (int i = 1; i <= 6; i++) pushw(0, i == 1, i == 6, i == 4, 16'hE000 + 16'(i));
    pushw(0, 1'b1, 1'b1, 1'b0, 16'hF001);
    pushw(1, 1'b1, 1'b0, 1'b0, 16'h9001);
    pushw(1, 1'b0, 1'b1, 1'b1, 16'h9002);
    for (int i = 1; i <= 3; i++) expw(1'b0, 1'b0, i == 1, 1'b0, 1'b0, 16'hE000 + 16'(i));
    expw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hE004);
    expw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9001);
    expw(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9002);
    expw(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hF001);
    refresh();
    drain("t4");
    check_eq("t4_len_err", 32'(len_err_cnt), 32'd1);

    // Headless 2-word fragment is dropped; a following packet still goes through.
    do_reset(1'b0);
    pushw(0, 1'b0, 1'b0, 1'b0, 16'h7001);
    pushw(0, 1'b0, 1'b1, 1'b0, 16'h7002);
    refresh();
    drain("t5_frag");
    pushw(0, 1'b1, 1'b1, 1'b0, 16'h7101);
    expw(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7101);
    refresh();
    drain("t5");

    // Reset during word 2 of a ch1 packet (after ch0 was served): outputs clear, ch0 wins next.
    do_reset(1'b0);
    pushw(0, 1'b1, 1'b1, 1'b0, 16'h5001);
    for (int i = 1; i <= 4; i++) pushw(1, i == 1, i == 4, 1'b0, 16'h6000 + 16'(i));
    expw(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h5001);
    expw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h6001);
    expw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h6002);
    refresh();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    check_eq("t6_pre_exp", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    refresh();
    tick();
    check_eq("t6_rst_outs", 32'({dout_s, vld_s, sop_s, eop_s, mod_s, len_s, gnt_s}), 32'd0);
    check_eq("t6_rst_rdreq", 32'({rd0_s, rd1_s}), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      pushw(0, i == 1, i == 2, 1'b0, 16'h4000 + 16'(i));
      pushw(1, i == 1, i == 2, 1'b0, 16'h3000 + 16'(i));
    end
    for (int i = 1; i <= 2; i++) expw(1'b0, 1'b0, i == 1, i == 2, 1'b0, 16'h4000 + 16'(i));
    for (int i = 1; i <= 2; i++) expw(1'b1, 1'b0, i == 1, i == 2, 1'b0, 16'h3000 + 16'(i));
    refresh();
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
